// File: rtl/dmem_stall_ctl.sv
// dmem_stall_ctl: multi-cycle data-memory access controller for the MEM stage.
// Drives a registered req/ack interface to data memory, stalls the upstream
// pipeline registers while an access is outstanding and bubbles MEM/WB.
// Optional macro DMEM_TIMEOUT_EN adds a BUSY timeout and a sticky ERR state.
module dmem_stall_ctl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_data_out,
    output logic        stall,
    output logic        mem_wb_bubble,
    output logic        dmem_err
);

`ifdef DMEM_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             access_req;
    logic             timeout_hit;

    assign access_req = mem_read | mem_write;

`ifdef DMEM_TIMEOUT_EN
    logic err_q;

    assign timeout_hit = (wait_cnt == CNT_LAST) && !dmem_ack;
    assign dmem_err    = err_q;

    // Sticky timeout flag, set on the BUSY cycle that exhausts the wait budget
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == BUSY && timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign dmem_err    = 1'b0;
`endif

    // State register; reset aborts any outstanding access back to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE ignores mem_read/mem_write since they still
    // belong to the instruction that just completed
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (access_req) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    next_state = DONE;
`ifdef DMEM_TIMEOUT_EN
                end else if (timeout_hit) begin
                    next_state = ERR;
`endif
                end
            end
            DONE: begin
                next_state = IDLE;
            end
`ifdef DMEM_TIMEOUT_EN
            ERR: begin
                next_state = ERR;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Stall/bubble outputs: asserted on the IDLE detect cycle, all of BUSY
    // and forever in ERR; forced low while reset is held
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = access_req;
                BUSY:    stall = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                ERR:     stall = 1'b1;
`endif
                default: stall = 1'b0;
            endcase
        end
        mem_wb_bubble = stall;
    end

    // Memory interface and load-data registers: capture the access in IDLE,
    // retire it on ack in BUSY, count wait cycles (saturating at the limit)
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            mem_data_out <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access_req) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= addr_in;
                        dmem_wdata <= wdata_in;
                        wait_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (wait_cnt != CNT_LAST) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            mem_data_out <= dmem_rdata;
                        end
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
